// File: rtl/grey_code_pkg.sv
// Shared constants and pure conversion helpers for the Gray-code block.
// Helpers work on a MaxWidth-wide word; callers zero-extend narrower words,
// which leaves the low bits of every result unchanged.
package grey_code_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned MaxWidth     = 16;

  // Binary to reflected Gray: each bit is the XOR of itself and the bit above.
  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: running XOR from the MSB downwards.
  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g);
    logic [MaxWidth-1:0] r;
    r[MaxWidth-1] = g[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

  // Odd parity: 1 when the word holds an odd number of ones.
  function automatic logic parity(input logic [MaxWidth-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/grey_code_conv.sv
// Purely combinational Gray conversion and parity.
// With GREY_CODE_DECODE_EN defined, a mode input selects Gray-to-binary.
module grey_code_conv
  import grey_code_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] b,
`ifdef GREY_CODE_DECODE_EN
  input  logic             mode,
`endif
  output logic [WIDTH-1:0] g,
  output logic             y
);

  logic [MaxWidth-1:0] b_ext;

  assign b_ext = MaxWidth'(b);

  // Select the conversion direction; encode is the default path.
  always_comb begin
    g = WIDTH'(bin2gray(b_ext));
`ifdef GREY_CODE_DECODE_EN
    if (mode) begin
      g = WIDTH'(gray2bin(b_ext));
    end
`endif
    y = parity(b_ext);
  end

endmodule

// File: rtl/grey_code.sv
// Gray-code converter with one cycle of latency and a valid flag.
// Optional feature macro: GREY_CODE_DECODE_EN adds the mode port and the
// Gray-to-binary path; without it the block is encode-only.
module grey_code
  import grey_code_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] B,
`ifdef GREY_CODE_DECODE_EN
  input  logic             mode,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] G,
  output logic             Y
);

  logic [WIDTH-1:0] conv_g;
  logic             conv_y;
  logic [WIDTH-1:0] g_q;
  logic             y_q;
  logic             valid_q;

  grey_code_conv #(
    .WIDTH (WIDTH)
  ) u_conv (
    .b    (B),
`ifdef GREY_CODE_DECODE_EN
    .mode (mode),
`endif
    .g    (conv_g),
    .y    (conv_y)
  );

  // Capture a result on every valid cycle; hold data otherwise, valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q     <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        g_q <= conv_g;
        y_q <= conv_y;
      end
    end
  end

  assign G         = g_q;
  assign Y         = y_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_grey_code.sv
// Self-checking bench for grey_code (WIDTH = 4): vector table, sweep with
// wrap, hold, asynchronous mid-stream reset and, when built with
// GREY_CODE_DECODE_EN, the decode path.
module tb_grey_code;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic [W-1:0] G;
  logic         Y;
`ifdef GREY_CODE_DECODE_EN
  logic         mode = 1'b0;
`endif

  grey_code #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .B         (B),
`ifdef GREY_CODE_DECODE_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .G         (G),
    .Y         (Y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         y;
  } vec_t;

  typedef struct {
    logic [W-1:0] g;
    logic         y;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] last_g = '0;
  logic         last_y = 1'b0;

  // Reference models, written bit by bit.
  function automatic logic [W-1:0] m_gray(input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i] = (i == W - 1) ? b[i] : (b[i] != b[i+1]);
    end
    return r;
  endfunction

  function automatic logic m_par(input logic [W-1:0] b);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(b[i]);
    return (ones % 2) == 1;
  endfunction

  function automatic int popcnt(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, check 1 time unit after the rise.
  task automatic step(input logic v, input logic [W-1:0] b, input logic [W-1:0] eg,
                      input logic ey, input string name);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    B = b;
    if (v) begin
      e.g = eg;
      e.y = ey;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check({name, ".valid"}, int'(out_valid), int'(v));
    if (v) begin
      if (sb.size() == 0) begin
        check({name, ".sb_empty"}, 0, 1);
      end else begin
        e = sb.pop_front();
        check({name, ".G"}, int'(G), int'(e.g));
        check({name, ".Y"}, int'(Y), int'(e.y));
        last_g = e.g;
        last_y = e.y;
      end
    end else begin
      check({name, ".G_hold"}, int'(G), int'(last_g));
      check({name, ".Y_hold"}, int'(Y), int'(last_y));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] prev_g;
    logic [W-1:0] bb;

    vecs.push_back('{b: 4'b0101, g: 4'b0111, y: 1'b0});
    vecs.push_back('{b: 4'b0001, g: 4'b0001, y: 1'b1});
    vecs.push_back('{b: 4'b1111, g: 4'b1000, y: 1'b0});
    vecs.push_back('{b: 4'b0000, g: 4'b0000, y: 1'b0});
    vecs.push_back('{b: 4'b0010, g: 4'b0011, y: 1'b1});
    vecs.push_back('{b: 4'b1010, g: 4'b1111, y: 1'b0});
    vecs.push_back('{b: 4'b0110, g: 4'b0101, y: 1'b0});

    // Reset state.
    #12;
    check("reset.G", int'(G), 0);
    check("reset.Y", int'(Y), 0);
    check("reset.valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table; the last entry (0110) leads into the hold test.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].b, vecs[i].g, vecs[i].y, $sformatf("vec%0d", i));
    end

    // in_valid low for three cycles while B wanders: G stays 0101.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, W'($urandom_range(0, 15)), '0, 1'b0, $sformatf("hold%0d", i));
      check($sformatf("hold%0d.G_const", i), int'(G), 4'b0101);
    end

    // Full sweep 0..15 then back to 0; adjacent codes differ in one bit.
    prev_g = '0;
    for (int i = 0; i <= 16; i++) begin
      bb = W'(i);
      step(1'b1, bb, m_gray(bb), m_par(bb), $sformatf("sweep%0d", i));
      if (i > 0) check($sformatf("sweep%0d.onebit", i), popcnt(G ^ prev_g), 1);
      prev_g = G;
    end

    // Asynchronous reset between edges mid-stream.
    step(1'b1, 4'b1101, m_gray(4'b1101), m_par(4'b1101), "pre_rst");
    @(negedge clk);
    in_valid = 1'b1;
    B = 4'b1110;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.G", int'(G), 0);
    check("async_rst.Y", int'(Y), 0);
    check("async_rst.valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("rst_hold.valid", int'(out_valid), 0);
    check("rst_hold.G", int'(G), 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    last_g = '0;
    last_y = 1'b0;
    step(1'b0, 4'b1110, '0, 1'b0, "post_rst_idle");
    step(1'b1, 4'b0011, 4'b0010, 1'b0, "post_rst");

`ifdef GREY_CODE_DECODE_EN
    // Decode path: mode sampled with B.
    @(negedge clk);
    mode = 1'b1;
    step(1'b1, 4'b0111, 4'b0101, 1'b1, "dec0111");
    step(1'b1, 4'b1000, 4'b1111, 1'b1, "dec1000");
    @(negedge clk);
    mode = 1'b0;
    step(1'b1, 4'b0111, 4'b0100, 1'b1, "enc0111");
`endif

    step(1'b0, '0, '0, 1'b0, "tail");
    check("sb.drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grey_code.md
GREY_CODE -- requirements
Module: grey_code

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the code word width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning B is to be sampled this cycle.
REQ-005 The block SHALL have port B, input, WIDTH bits, the unsigned binary input word.
REQ-006 The block SHALL have port out_valid, output, 1 bit, meaning G and Y hold a freshly converted result.
REQ-007 The block SHALL have port G, output, WIDTH bits, the Gray-coded word.
REQ-008 The block SHALL have port Y, output, 1 bit, the odd-parity flag of the sampled B.
REQ-009 The block SHALL have port mode, input, 1 bit, present only when GREY_CODE_DECODE_EN is defined: 0 = binary-to-Gray, 1 = Gray-to-binary.

Function
REQ-010 Conversion SHALL be G[WIDTH-1] = B[WIDTH-1] and G[i] = B[i+1] XOR B[i] for i < WIDTH-1.
REQ-011 Y SHALL be the XOR reduction of all bits of the sampled B: 1 when B has an odd number of ones.
REQ-012 Latency SHALL be exactly one clock: in_valid=1 at edge N makes G, Y and out_valid=1 visible after edge N.
REQ-013 With in_valid=0 at an edge, out_valid SHALL go 0 and G and Y SHALL hold their previous values.
REQ-014 Back-to-back in_valid SHALL be accepted every cycle with no stalls; there is no backpressure.
REQ-015 For B incrementing by 1 modulo 2^WIDTH, including the wrap from all-ones to zero, consecutive G values SHALL differ in exactly one bit.
REQ-016 In decode mode (mode=1), G SHALL carry the binary value with G[WIDTH-1] = B[WIDTH-1] and G[i] = G[i+1] XOR B[i], and Y SHALL be the parity of B.
REQ-017 mode SHALL be sampled in the same cycle as B when in_valid=1.

Reset
REQ-018 rst_n low SHALL immediately, without waiting for a clock edge, force G to 0, Y to 0 and out_valid to 0.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight sample; the first valid sample after release SHALL produce out_valid one clock later.
REQ-020 Reset SHALL be released synchronously by the integrating system; the block adds no reset synchronizer.

Configuration
REQ-021 Macro GREY_CODE_DECODE_EN SHALL control the decode feature.
REQ-022 When GREY_CODE_DECODE_EN is defined, the mode port and the Gray-to-binary path SHALL exist.
REQ-023 When GREY_CODE_DECODE_EN is undefined, the mode port SHALL be absent and the block SHALL be encode-only.

Structure
REQ-024 Package grey_code_pkg SHALL hold the default WIDTH constant and the pure functions bin2gray, gray2bin and parity.
REQ-025 Sub-module grey_code_conv SHALL hold the purely combinational conversion and parity logic.
REQ-026 The top level SHALL hold only the input sampling, the output registers and the valid register.

Verification
REQ-027 Reset then in_valid=1, B=4'b0101 -> next cycle G=4'b0111, Y=0, out_valid=1.
REQ-028 Sweep B over 0000..1111 with in_valid=1 each cycle -> G = 0000,0001,0011,0010,...,1000; Y matches the parity of B; adjacent G values differ in one bit, including 1000 -> 0000 on wrap.
REQ-029 B=4'b0001 -> G=4'b0001, Y=1; B=4'b1111 -> G=4'b1000, Y=0.
REQ-030 in_valid=0 for 3 cycles after B=4'b0110 -> G holds 4'b0101, out_valid=0.
REQ-031 rst_n driven low between clock edges during a sweep -> G=0, Y=0, out_valid=0 immediately; after release, B=4'b0011 -> G=4'b0010.
REQ-032 With GREY_CODE_DECODE_EN defined, mode=1, B=4'b0111 -> G=4'b0101, Y=1.
